// File: rtl/tx_pkg.sv
// Shared types and helpers for the word transmit serializer.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        GUARD,
        WAIT
    } tx_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    // Little-endian byte pick: index 0 is bits 7:0.
    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] result;
        case (idx)
            2'd0:    result = word[7:0];
            2'd1:    result = word[15:8];
            2'd2:    result = word[23:16];
            default: result = word[31:24];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Word FIFO with wrap-bit pointers; full and empty come straight from the
// pointer registers, so nothing depends combinationally on push.
module word_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                push_ok;
    logic                pop_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // A push while full is dropped even if a pop frees a slot that cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !reset) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/word_tx_serializer.sv
// Buffers 32-bit core words and feeds them little-endian, byte by byte, to the UART sender.
// Optional macro TX_LED_EN adds led[15:0], the low half of a count of fully sent words.
module word_tx_serializer
    import tx_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  word_valid,
    input  logic [31:0]           word_data,
    output logic                  word_ready,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            sdata,
    output logic                  tx_idle,
`ifdef TX_LED_EN
    output logic [15:0]           led,
`endif
    output logic [DEPTH_LOG2:0]   word_count
);

    localparam logic [DEPTH_LOG2:0] COUNT_ONE = 1;

    tx_state_t   state;
    logic [1:0]  idx;
    logic [31:0] head_word;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        more_words;

    word_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (32)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (word_valid),
        .push_data (word_data),
        .pop       (pop),
        .head      (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (word_count)
    );

    assign word_ready = ~fifo_full;
    assign tx_idle    = (state == IDLE) && fifo_empty;

    // The head word stays in the FIFO until its last byte has gone out.
    assign pop        = (state == WAIT) && !tx_busy && (idx == LAST_IDX);
    assign more_words = (word_count > COUNT_ONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= 2'd0;
            tx_start <= 1'b0;
            sdata    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (!fifo_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    sdata    <= select_byte(head_word, idx);
                    tx_start <= 1'b1;
                    state    <= GUARD;
                end
                // The sender only raises tx_busy a cycle after tx_start.
                GUARD: begin
                    tx_start <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    tx_start <= 1'b0;
                    if (!tx_busy) begin
                        if (idx == LAST_IDX) begin
                            idx   <= 2'd0;
                            state <= more_words ? LOAD : IDLE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= LOAD;
                        end
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef TX_LED_EN
    logic [31:0] words_sent;

    always_ff @(posedge clock) begin
        if (reset) begin
            words_sent <= 32'd0;
        end else if (pop) begin
            words_sent <= words_sent + 32'd1;
        end
    end

    assign led = words_sent[15:0];
`endif

endmodule

// File: tb/tb_word_tx_serializer.sv
// Directed bench for word_tx_serializer with a simple UART sender model.
module tb_word_tx_serializer;

    localparam int DEPTH_LOG2 = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  sdata;
    logic        tx_idle;
    logic [3:0]  word_count;
`ifdef TX_LED_EN
    logic [15:0] led;
`endif

    int compared   = 0;
    int mismatched = 0;

    int   busy_len  = 0;
    int   busy_left = 0;
    bit   pending   = 1'b0;
    logic [7:0] capture [$];

    typedef struct {
        logic [31:0]     word;
        int              busy;
        logic [3:0][7:0] exp;
    } vec_t;

    vec_t vecs [4];

    always #5 clock = ~clock;

    word_tx_serializer #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .sdata      (sdata),
        .tx_idle    (tx_idle),
`ifdef TX_LED_EN
        .led        (led),
`endif
        .word_count (word_count)
    );

    // Sender model: latches sdata on tx_start, raises busy one cycle later.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                busy_left = 0;
                pending   = 1'b0;
                tx_busy   = 1'b0;
            end else begin
                if (pending) begin
                    busy_left = busy_len;
                    tx_busy   = (busy_len > 0);
                    pending   = 1'b0;
                end else if (busy_left > 0) begin
                    busy_left--;
                    tx_busy = (busy_left > 0);
                end
                if (tx_start === 1'b1) begin
                    capture.push_back(sdata);
                    pending = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] w);
        @(negedge clock);
        word_valid = 1'b1;
        word_data  = w;
        @(negedge clock);
        word_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n = 0;
        while (tx_idle !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput({name, " idle"}, {31'd0, tx_idle}, 32'd1);
    endtask

    task automatic checkBytes(input string name, input int base, input logic [3:0][7:0] exp);
        for (int b = 0; b < 4; b++) begin
            checkOutput($sformatf("%s byte%0d", name, b),
                        (base + b < capture.size()) ? {24'd0, capture[base + b]} : 32'hFFFF_FFFF,
                        {24'd0, exp[b]});
        end
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, " word_ready"}, {31'd0, word_ready}, 32'd1);
        checkOutput({name, " tx_start"},   {31'd0, tx_start},   32'd0);
        checkOutput({name, " sdata"},      {24'd0, sdata},      32'd0);
        checkOutput({name, " tx_idle"},    {31'd0, tx_idle},    32'd1);
        checkOutput({name, " word_count"}, {28'd0, word_count}, 32'd0);
    endtask

    initial begin
        int base;
        int n;
        logic [3:0][7:0] exp;

        vecs[0] = '{word: 32'h1122_3344, busy: 10, exp: {8'h11, 8'h22, 8'h33, 8'h44}};
        vecs[1] = '{word: 32'hA5A5_0F0F, busy: 0,  exp: {8'hA5, 8'hA5, 8'h0F, 8'h0F}};
        vecs[2] = '{word: 32'h0000_00FF, busy: 3,  exp: {8'h00, 8'h00, 8'h00, 8'hFF}};
        vecs[3] = '{word: 32'h8001_7E42, busy: 1,  exp: {8'h80, 8'h01, 8'h7E, 8'h42}};

        reset      = 1'b1;
        word_valid = 1'b0;
        word_data  = 32'd0;
        repeat (2) @(negedge clock);
        checkResetValues("reset");
        reset = 1'b0;

        // Single words through the sender model with various busy lengths.
        for (int v = 0; v < 4; v++) begin
            busy_len = vecs[v].busy;
            base     = capture.size();
            applyStimulus(vecs[v].word);
            checkOutput($sformatf("tbl%0d count after push", v), {28'd0, word_count}, 32'd1);
            waitIdle(1000, $sformatf("tbl%0d", v));
            checkOutput($sformatf("tbl%0d byte total", v), capture.size() - base, 32'd4);
            checkBytes($sformatf("tbl%0d", v), base, vecs[v].exp);
            checkOutput($sformatf("tbl%0d count after send", v), {28'd0, word_count}, 32'd0);
        end

        // Busy never asserts: first pulse two cycles after push, then every three.
        busy_len = 0;
        base     = capture.size();
        @(negedge clock);
        word_valid = 1'b1;
        word_data  = 32'hCAFE_F00D;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            word_valid = 1'b0;
            checkOutput($sformatf("spacing tx_start @%0d", i), {31'd0, tx_start}, {31'd0, (i % 3) == 2});
        end
        waitIdle(100, "spacing");
        checkBytes("spacing", base, {8'hCA, 8'hFE, 8'hF0, 8'h0D});

        // Overfill: nine words into an eight-deep FIFO with a slow sender.
        busy_len = 50;
        base     = capture.size();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checkOutput($sformatf("fill ready before push%0d", i), {31'd0, word_ready}, 32'd1);
            word_valid = 1'b1;
            word_data  = 32'h1000_0000 + i * 32'h0101_0101;
        end
        @(negedge clock);
        checkOutput("full ready", {31'd0, word_ready}, 32'd0);
        checkOutput("full count", {28'd0, word_count}, 32'd8);
        word_data = 32'h1000_0000 + 8 * 32'h0101_0101;
        @(negedge clock);
        checkOutput("push when full ignored", {28'd0, word_count}, 32'd8);
        n = 0;
        while (word_ready !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checkOutput("ready after first pop", {31'd0, word_ready}, 32'd1);
        checkOutput("push refused on pop cycle", {28'd0, word_count}, 32'd7);
        @(negedge clock);
        word_valid = 1'b0;
        checkOutput("push accepted after pop", {28'd0, word_count}, 32'd8);
        waitIdle(5000, "overfill");
        checkOutput("overfill byte total", capture.size() - base, 32'd36);
        for (int i = 0; i < 9; i++) begin
            exp = 32'h1000_0000 + i * 32'h0101_0101;
            checkBytes($sformatf("overfill w%0d", i), base + 4 * i, exp);
        end

        // Reset while the third byte of a word is in flight.
        busy_len = 5;
        base     = capture.size();
        applyStimulus(32'hDEAD_BEEF);
        n = 0;
        while (capture.size() - base < 3 && n < 500) begin
            @(negedge clock);
            n++;
        end
        checkOutput("midreset reached byte2", capture.size() - base, 32'd3);
        reset = 1'b1;
        @(negedge clock);
        checkResetValues("midreset");
        reset = 1'b0;
        repeat (20) @(negedge clock);
        checkOutput("midreset no further start", capture.size() - base, 32'd3);
        checkOutput("midreset idle", {31'd0, tx_idle}, 32'd1);
        exp = {8'h00, 8'hAD, 8'hBE, 8'hEF};
        for (int b = 0; b < 3; b++) begin
            checkOutput($sformatf("midreset byte%0d", b),
                        (base + b < capture.size()) ? {24'd0, capture[base + b]} : 32'hFFFF_FFFF,
                        {24'd0, exp[b]});
        end
        base = capture.size();
        applyStimulus(32'h0000_00AA);
        waitIdle(500, "after reset");
        checkBytes("after reset", base, {8'h00, 8'h00, 8'h00, 8'hAA});

`ifdef TX_LED_EN
        reset = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        busy_len = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h0102_0304 + i);
        end
        waitIdle(500, "led");
        checkOutput("led after three words", {16'd0, led}, 32'd3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("led after reset", {16'd0, led}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/word_tx_serializer.md
Name: word_tx_serializer

Overview:
- Transmit-side counterpart of the UART loader path: accepts 32-bit words from the core (output-instruction results, status words) and serializes each into 4 bytes for the external UART sender.
- Byte order little-endian (byte 0 = bits 7:0 first), matching the host-side convention used for program size, program and data.
- Small word FIFO decouples core issue rate from UART bit rate; sits between core I/O port and the UART sender.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 words (8); legal range 1..6.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- word_valid  in  1  core presents word_data this cycle
- word_data  in  32  word to send
- word_ready  out  1  FIFO can accept; transfer when word_valid & word_ready
- tx_busy  in  1  UART sender busy shifting a byte
- tx_start  out  1  one-cycle pulse, sender latches sdata
- sdata  out  8  byte to send, stable from tx_start until next tx_start
- tx_idle  out  1  FIFO empty and no byte in flight
- word_count  out  DEPTH_LOG2+1  current FIFO occupancy

Behaviour:
- Reset values: word_ready=1, tx_start=0, sdata=8'h00, tx_idle=1, word_count=0; FIFO pointers 0, FSM IDLE, byte index 0. Reset mid-byte discards FIFO contents and in-flight word; no tx_start after reset until new word pushed.
- FIFO: DEPTH entries, rd/wr pointers DEPTH_LOG2+1 bits (extra wrap bit); full when pointers differ only in MSB; empty when equal. word_ready = ~full (registered-equivalent, no combinational path from word_valid). Push when full ignored. Simultaneous push+pop when full: pop occurs, push refused (word_ready was 0). Push+pop when not full: occupancy unchanged.
- FSM states:
  - IDLE: if FIFO non-empty -> LOAD.
  - LOAD: sdata <= head_word[8*idx +: 8]; tx_start <= 1; -> GUARD.
  - GUARD: tx_start <= 0; one-cycle hold since sender raises tx_busy one cycle after tx_start; -> WAIT.
  - WAIT: when tx_busy==0: if idx==3 {pop FIFO, idx<=0; -> LOAD if FIFO holds another word after this pop, else IDLE} else {idx<=idx+1; -> LOAD}.
- tx_start high exactly 1 cycle per byte; minimum 3 cycles between consecutive tx_start pulses even if tx_busy never asserts.
- Word push to first tx_start latency: 2 cycles (push cycle N, IDLE sees non-empty N+1, tx_start high N+2).
- Head word not popped until its 4th byte completes; word_count includes the word in flight.
- tx_idle = (state==IDLE) & empty.
- idx 2 bits, wraps 3->0 only via pop.

Optional Feature:
- TX_LED_EN: adds output led[15:0] = low 16 bits of a 32-bit counter of words fully transmitted (incremented on pop), reset to 16'h0000. Without the macro the port and counter do not exist.

Decomposition:
- Package tx_pkg: FSM enum tx_state_t {IDLE, LOAD, GUARD, WAIT}, constant BYTES_PER_WORD=4.
- Sub-module word_fifo (parameter DEPTH_LOG2, WIDTH=32; push/pop/full/empty/count); FSM and byte select stay in word_tx_serializer.

Test Plan:
- Single word 32'h11223344 pushed, sender model with 10-cycle busy -> sdata sequence 44,33,22,11, four tx_start pulses, tx_idle returns 1, word_count 1->0.
- Push 9 words back-to-back with DEPTH_LOG2=3, sender busy 50 cycles -> word_ready drops after 8th push, 9th held until first pop, all 36 bytes in order.
- tx_busy tied 0 -> tx_start pulses exactly every 3 cycles; first pulse 2 cycles after push.
- Push on same cycle as pop of last byte of a full FIFO -> push refused, count stays DEPTH-1 then next push accepted.
- Reset asserted during byte index 2 of word 32'hDEADBEEF -> outputs at reset values next cycle, no further tx_start, new word 32'h000000AA sends AA,00,00,00.
- With TX_LED_EN, send 3 words -> led==16'h0003; reset -> led==0.
